instr_fetch: RTL

Instruction fetch controller for the simple 8-bit CPU, directly upstream of the program RAM. It owns the program counter, drives the RAM's address, `read` and active-low `ena` strobes with the sequencing the RAM needs, and captures each byte returned. Fetched bytes go into a one-entry instruction register and are offered to the decoder over a valid/ready handshake. The decoder can redirect the PC with a jump request.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_pc.sv | 24 ++
 rtl/instr_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: default bus widths and the fetch FSM encoding.
package cpu_pkg;

    localparam int CPU_AW = 6;
    localparam int CPU_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        READ  = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: async reset to RESET_PC, jump load beats increment, wraps modulo 2^AW.
module fetch_pc #(
    parameter int AW       = 6,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= AW'(RESET_PC);
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch controller: sequences program-RAM strobes, captures bytes into a
// one-entry instruction register and hands them to the decoder over valid/ready.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int AW       = CPU_AW,
    parameter int DW       = CPU_DW,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_ena,
    input  logic [DW-1:0] mem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    input  logic          jmp_valid,
    input  logic [AW-1:0] jmp_addr
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic [AW-1:0] pc;
    logic          handshake;
    logic          read_next;

    assign handshake = out_valid && out_ready;

    fetch_pc #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (jmp_valid),
        .load_addr (jmp_addr),
        .inc       (state == READ),
        .pc        (pc)
    );

    // The PC only changes at the edge ending READ or on a jump, so it doubles as the RAM address.
    assign mem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (run) next_state = SETUP;
            SETUP:   next_state = READ;
            READ:    next_state = VALID;
            VALID:   if (handshake) next_state = run ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
        if (jmp_valid) begin
            next_state = run ? SETUP : IDLE;
        end
    end

    always_comb begin
        read_next = (next_state == READ);
    end

    // Strobes come straight from flops so reset forces them idle without an ena=0 glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read <= 1'b0;
            mem_ena  <= 1'b1;
        end else begin
            mem_read <= read_next;
            mem_ena  <= !read_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (jmp_valid) begin
            out_valid <= 1'b0;
        end else if (state == READ) begin
            out_valid <= 1'b1;
            out_instr <= mem_data;
            out_pc    <= pc;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

endmodule
